// File: rtl/sync_down_timer.sv
// Loadable synchronous down-counter/timer with one-shot or periodic (auto-reload) operation.
// Latency: tc registered, asserted in the cycle after the terminal decrement edge (N enabled edges after load).
// No backpressure: en gates counting, load always wins over en, reset wins over everything.
// Optional prescaler enabled by defining SDT_PRESCALE_EN (one decrement per PRESCALE enabled cycles).
module sync_down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             tc_q, tc_d;

  // Qualifies an enabled cycle as one that actually moves the count.
  logic             dec_step;

`ifdef SDT_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          presc_wrap;

  assign presc_wrap = (presc_q == PW'(PRESCALE - 1));
  assign dec_step   = en && presc_wrap;

  // Prescale counter: counts enabled RUN cycles, restarts on load and on every decrement.
  always_comb begin
    presc_d = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (state_q == S_RUN && en) begin
      presc_d = presc_wrap ? '0 : presc_q + PW'(1);
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign dec_step = en;
`endif

  // Next-state logic: load dominates, then RUN-state counting; IDLE and DONE hold.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      mode_d   = mode;
      state_d  = (load_val != '0) ? S_RUN : S_IDLE;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (dec_step) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = S_DONE;
              end
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end else begin
              // A zero count cannot be reached in RUN; park safely if it ever is.
              state_d = S_IDLE;
            end
          end
        end
        S_DONE: begin
          count_d = '0;
        end
        S_IDLE: begin
          count_d = count_q;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign count_out = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sync_down_timer.sv
// Self-checking bench for sync_down_timer (default build, prescaler disabled).
module tb_sync_down_timer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             mode;
  logic             en;
  logic [WIDTH-1:0] count_out;
  logic             tc;
  logic             busy;
  logic             done;

  int checks;
  int fails;

  // Behavioural reference: the timer seen as "remaining ticks" plus phase flags.
  int  m_count;
  int  m_reload;
  bit  m_periodic;
  bit  m_running;
  bit  m_expired;
  bit  m_tc;

  sync_down_timer #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .en       (en),
    .count_out(count_out),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, let the edge happen, then advance the reference.
  task automatic tick(input bit r, input bit ld, input int lv, input bit md, input bit e);
    reset    = r;
    load     = ld;
    load_val = lv[WIDTH-1:0];
    mode     = md;
    en       = e;
    @(posedge clk);
    #1;
    m_tc = 1'b0;
    if (r) begin
      m_count = 0; m_reload = 0; m_periodic = 0; m_running = 0; m_expired = 0;
    end else if (ld) begin
      m_count    = lv;
      m_reload   = lv;
      m_periodic = md;
      m_expired  = 0;
      m_running  = (lv != 0);
    end else if (m_running && e) begin
      if (m_count == 1) begin
        m_tc = 1'b1;
        if (m_periodic) m_count = m_reload;
        else begin
          m_count = 0; m_running = 0; m_expired = 1;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(i < 2, 1'b1 && (i < 2), 9, 1'b1, 1'b1);
      checks++;
      if (count_out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL reset[%0d]: got count=%0d tc=%b busy=%b done=%b, want 0 0 0 0",
                 i, count_out, tc, busy, done);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_cnt [6] = '{5, 4, 3, 2, 1, 0};
    for (int i = 0; i < 16; i++) begin
      int  ec;
      bit  etc;
      tick(1'b0, i == 0, 5, 1'b0, 1'b1);
      ec  = (i < 6) ? exp_cnt[i] : 0;
      etc = (i == 5);
      checks++;
      if (count_out !== ec[WIDTH-1:0] || tc !== etc || busy !== (i < 5) || done !== (i >= 5)
          || count_out !== m_count[WIDTH-1:0] || tc !== m_tc) begin
        fails++;
        $display("FAIL oneshot[%0d]: got count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                 i, count_out, tc, busy, done, ec, etc, (i < 5), (i >= 5));
      end
    end
  endtask

  task automatic test_periodic();
    int exp_cnt [10] = '{3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
    for (int i = 0; i < 10; i++) begin
      bit etc;
      tick(1'b0, i == 0, 3, 1'b1, 1'b1);
      etc = (i == 3 || i == 6 || i == 9);
      checks++;
      if (count_out !== exp_cnt[i][WIDTH-1:0] || tc !== etc || busy !== 1'b1 || done !== 1'b0
          || tc !== m_tc) begin
        fails++;
        $display("FAIL periodic[%0d]: got count=%0d tc=%b busy=%b done=%b, want %0d %b 1 0",
                 i, count_out, tc, busy, done, exp_cnt[i], etc);
      end
    end
  endtask

  task automatic test_enable_hold();
    // Edges after load: 3,2, hold 2,2, then 1, then 0 with tc on edge 6.
    int exp_cnt [7] = '{4, 3, 2, 2, 2, 1, 0};
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, i == 0, 4, 1'b0, !(i == 3 || i == 4));
      checks++;
      if (count_out !== exp_cnt[i][WIDTH-1:0] || tc !== (i == 6) || done !== (i == 6)
          || count_out !== m_count[WIDTH-1:0]) begin
        fails++;
        $display("FAIL enable_hold[%0d]: got count=%0d tc=%b done=%b, want %0d %b %b",
                 i, count_out, tc, done, exp_cnt[i], (i == 6), (i == 6));
      end
    end
  endtask

  task automatic test_reload_restart();
    tick(1'b0, 1'b1, 0, 1'b0, 1'b1);
    checks++;
    if (count_out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL load_zero: got count=%0d busy=%b tc=%b done=%b, want 0 0 0 0",
               count_out, busy, tc, done);
    end
    tick(1'b0, 1'b1, 15, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (count_out !== 4'd7 || busy !== 1'b1) begin
      fails++;
      $display("FAIL count_15_to_7: got count=%0d busy=%b, want 7 1", count_out, busy);
    end
    tick(1'b0, 1'b1, 9, 1'b0, 1'b1);
    checks++;
    if (count_out !== 4'd9 || tc !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reload_mid_run: got count=%0d tc=%b busy=%b, want 9 0 1", count_out, tc, busy);
    end
    for (int i = 1; i <= 9; i++) begin
      tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (count_out !== 4'(9 - i) || tc !== (i == 9)) begin
        fails++;
        $display("FAIL after_reload[%0d]: got count=%0d tc=%b, want %0d %b",
                 i, count_out, tc, 9 - i, (i == 9));
      end
    end
  endtask

  task automatic test_reset_midrun();
    tick(1'b0, 1'b1, 8, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (count_out !== 4'd6 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got count=%0d busy=%b, want 6 1", count_out, busy);
    end
    tick(1'b1, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (count_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL reset_midrun: got count=%0d busy=%b done=%b tc=%b, want 0 0 0 0",
               count_out, busy, done, tc);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (count_out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
        fails++;
        $display("FAIL idle_after_reset[%0d]: got count=%0d busy=%b tc=%b, want 0 0 0",
                 i, count_out, busy, tc);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit r, ld, md, e;
      int lv;
      r  = ($urandom_range(0, 63) == 0);
      ld = ($urandom_range(0, 15) == 0);
      md = $urandom_range(0, 1);
      e  = ($urandom_range(0, 3) != 0);
      lv = (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15));
      tick(r, ld, lv, md, e);
      checks++;
      if (count_out !== m_count[WIDTH-1:0] || tc !== m_tc || busy !== m_running
          || done !== m_expired) begin
        fails++;
        $display("FAIL random[%0d]: got count=%0d tc=%b busy=%b done=%b, want %0d %b %b %b",
                 i, count_out, tc, busy, done, m_count, m_tc, m_running, m_expired);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    m_count = 0; m_reload = 0; m_periodic = 0; m_running = 0; m_expired = 0; m_tc = 0;
    reset = 1'b0; load = 1'b0; load_val = '0; mode = 1'b0; en = 1'b0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_enable_hold();
    test_reload_restart();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sync_down_timer.md
Name: sync_down_timer

Overview:
- Fully synchronous, loadable down-counter/timer. It is the counterpart to the free-running up-counter.
- Counts from a loaded value toward zero and flags terminal count.
- Runs one-shot or periodic (auto-reload) and sits in front of lab sequencing and stopwatch blocks.
- Single clock domain; no derived or ripple clocks.

Parameters:
- WIDTH, 4, width of count and load value (max count 2^WIDTH-1).
- PRESCALE, 4, enabled cycles per decrement; used only when SDT_PRESCALE_EN is defined; must be >= 1.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture load_val and mode, then start counting.
- load_val  input  WIDTH  start and reload value.
- mode  input  1  0 = one-shot, 1 = periodic; sampled only when load=1.
- en  input  1  count enable; 0 holds the count.
- count_out  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, one cycle wide, registered.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE (one-shot expired).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. It is sampled only on the rising edge of clk.
- Reset: at the edge where reset=1, the block clears all state.
  - count_out=0, tc=0, busy=0, done=0.
  - Reload register=0, mode register=0, state=IDLE.
  - reset overrides load and en.
- States: IDLE, RUN, DONE.
- load=1 (any state, reset=0): the next edge does the following.
  - count_out<=load_val, reload_reg<=load_val, mode_reg<=mode, tc<=0, done<=0.
  - If load_val!=0, go to RUN with busy=1.
  - If load_val==0, go to IDLE with busy=0 and no tc.
  - load has priority over en in the same cycle. Loading during RUN restarts the count and produces no tc.
- RUN, en=0: the block holds count_out, tc=0.
- RUN, en=1, count_out>1: count_out decrements by 1.
- RUN, en=1, count_out==1: the block asserts tc=1 for exactly that next cycle.
  - One-shot: count_out<=0, state DONE, busy=0, done=1.
  - Periodic: count_out<=reload_reg, stay in RUN, busy stays 1. count_out never shows 0 in periodic mode.
- tc is 0 in every cycle except the one following a terminal decrement.
- DONE: holds count_out=0 and done=1, and ignores en until load or reset.
- IDLE: holds count_out, ignores en.
- No underflow or wrap is possible; the counter never decrements from 0.
- Latency: tc rises at the Nth enabled edge after the load edge (N = load_val, prescaler disabled).
- Arithmetic: unsigned, WIDTH bits, no carry out.

Optional Feature:
- SDT_PRESCALE_EN defined:
  - An internal prescale counter (ceil(log2(PRESCALE)) bits) counts cycles with en=1 while in RUN.
  - A decrement (and any tc) occurs only on every PRESCALE-th enabled cycle.
  - The prescale counter clears on reset, on load and on each decrement; en=0 holds it.
  - Load value N therefore takes N*PRESCALE enabled cycles to reach tc.
- SDT_PRESCALE_EN undefined: no prescaler logic; the PRESCALE parameter is ignored and a decrement occurs on every enabled cycle.

Test Plan:
- Reset held 2 cycles with load=1, en=1 -> count_out=0, tc=0, busy=0, done=0 throughout; stays 0 after release with load=0.
- load 5, mode=0, en=1 continuously -> count_out 5,4,3,2,1,0 on successive edges. tc=1 only in the cycle count_out becomes 0. Then busy=0, done=1, and count_out holds 0 for 10 further cycles.
- load 3, mode=1, en=1 -> count_out 3,2,1,3,2,1,3. tc pulses every 3 cycles, coincident with each return to 3. busy stays 1 and done stays 0.
- load 4, mode=0; en low for 2 cycles when count_out=2 -> count holds at 2 for 2 cycles; tc arrives 6 edges after load instead of 4.
- load 0 -> busy=0, no tc. Then load 15 and en=1; at count_out=7 pulse load with load_val=9 and en=1 -> next count_out=9, no tc; tc at 9 further edges.
- Periodic run at count_out=6, assert reset one cycle -> next edge count_out=0, busy=0, done=0, tc=0. Then en=1 without load -> count_out stays 0.
- With SDT_PRESCALE_EN, PRESCALE=4: load 2, en=1 -> count_out changes every 4 cycles; tc at edge 8 after load.
